// File: rtl/knn_sched.sv
// KNN classifier sequencer: streams training points from memory, computes squared
// distances to a latched test point and keeps a sorted list of the K nearest neighbours.
module knn_sched #(
    parameter int COORD_W = 16,
    parameter int LABEL_W = 8,
    parameter int N_W     = 10,
    parameter int K       = 10,
    parameter int DIST_W  = 2*COORD_W+1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2*COORD_W-1:0]   test_pt,
    input  logic [N_W-1:0]         n_points,
    output logic                   mem_rd,
    output logic [N_W-1:0]         mem_addr,
    input  logic [2*COORD_W-1:0]   mem_pt,
    input  logic [LABEL_W-1:0]     mem_label,
    output logic                   busy,
    output logic                   done,
    output logic [N_W-1:0]         nb_count,
    output logic [K*DIST_W-1:0]    nb_dist,
    output logic [K*LABEL_W-1:0]   nb_label
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DIST   = 3'd3,
        S_INSERT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Squared Euclidean distance; coordinate differences need one extra bit and the
    // sum of two squares of 17-bit values always fits in DIST_W unsigned bits.
    function automatic logic [DIST_W-1:0] sq_dist(
        input logic [2*COORD_W-1:0] a,
        input logic [2*COORD_W-1:0] b
    );
        logic signed [COORD_W:0]     dx;
        logic signed [COORD_W:0]     dy;
        logic signed [2*COORD_W+1:0] ex;
        logic signed [2*COORD_W+1:0] ey;
        logic signed [2*COORD_W+1:0] sum;
        dx  = $signed({a[2*COORD_W-1], a[2*COORD_W-1:COORD_W]})
            - $signed({b[2*COORD_W-1], b[2*COORD_W-1:COORD_W]});
        dy  = $signed({a[COORD_W-1], a[COORD_W-1:0]})
            - $signed({b[COORD_W-1], b[COORD_W-1:0]});
        ex  = {{(COORD_W+1){dx[COORD_W]}}, dx};
        ey  = {{(COORD_W+1){dy[COORD_W]}}, dy};
        sum = ex*ex + ey*ey;
        return sum[DIST_W-1:0];
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [2*COORD_W-1:0]   test_r;
    logic [N_W-1:0]         n_r;
    logic [2*COORD_W-1:0]   pt_r;
    logic [LABEL_W-1:0]     lab_in_r;
    logic [DIST_W-1:0]      d_r;
    logic [N_W-1:0]         idx_r;
    logic [DIST_W-1:0]      dist_r [K];
    logic [LABEL_W-1:0]     lab_r  [K];
    logic [N_W-1:0]         count_r;
    logic                   mem_rd_r;
    logic [N_W-1:0]         mem_addr_r;
    logic                   busy_r;
    logic                   done_r;

    logic                   accept_s;
    logic                   capture_s;
    logic                   dist_en_s;
    logic                   insert_s;
    logic                   last_s;
    logic [N_W-1:0]         idx_nxt_s;
    logic                   mem_rd_nxt_s;
    logic [N_W-1:0]         mem_addr_nxt_s;
    logic                   busy_nxt_s;
    logic                   done_nxt_s;
    logic [K-1:0]           le_s;
    logic [DIST_W-1:0]      ins_dist_s [K];
    logic [LABEL_W-1:0]     ins_lab_s  [K];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign last_s = (idx_r == (n_r - N_W'(1)));

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = (n_points == {N_W{1'b0}}) ? S_DONE : S_FETCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH:  state_nxt_s = S_WAIT;
            S_WAIT:   state_nxt_s = S_DIST;
            S_DIST:   state_nxt_s = S_INSERT;
            S_INSERT: state_nxt_s = last_s ? S_DONE : S_FETCH;
            S_DONE:   state_nxt_s = S_IDLE;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Output/control decode; outputs are registered one edge later
    always_comb begin
        accept_s  = (state_r == S_IDLE) && start;
        capture_s = (state_r == S_WAIT);
        dist_en_s = (state_r == S_DIST);
        insert_s  = (state_r == S_INSERT);

        if (accept_s) begin
            idx_nxt_s = {N_W{1'b0}};
        end else if (insert_s && !last_s) begin
            idx_nxt_s = idx_r + N_W'(1);
        end else begin
            idx_nxt_s = idx_r;
        end

        mem_rd_nxt_s   = (state_nxt_s == S_FETCH);
        mem_addr_nxt_s = mem_rd_nxt_s ? idx_nxt_s : mem_addr_r;
        done_nxt_s     = (state_r == S_DONE);

        if (accept_s) begin
            busy_nxt_s = 1'b1;
        end else if (state_r == S_DONE) begin
            busy_nxt_s = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
    end

    // Control outputs and run context
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_rd_r   <= 1'b0;
            mem_addr_r <= {N_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            idx_r      <= {N_W{1'b0}};
            test_r     <= {(2*COORD_W){1'b0}};
            n_r        <= {N_W{1'b0}};
        end else begin
            mem_rd_r   <= mem_rd_nxt_s;
            mem_addr_r <= mem_addr_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            idx_r      <= idx_nxt_s;
            if (accept_s) begin
                test_r <= test_pt;
                n_r    <= n_points;
            end
        end
    end

    // Fetched point capture and distance pipeline stage
    always_ff @(posedge clk) begin
        if (!rst) begin
            pt_r     <= {(2*COORD_W){1'b0}};
            lab_in_r <= {LABEL_W{1'b0}};
            d_r      <= {DIST_W{1'b0}};
        end else begin
            if (capture_s) begin
                pt_r     <= mem_pt;
                lab_in_r <= mem_label;
            end
            if (dist_en_s) begin
                d_r <= sq_dist(test_r, pt_r);
            end
        end
    end

    // Sorted-insert network: entries with dist <= d form a prefix, so the candidate
    // lands just after the last such entry and later entries slide down by one.
    always_comb begin
        le_s       = {K{1'b0}};
        ins_dist_s = dist_r;
        ins_lab_s  = lab_r;
        for (int i = 0; i < K; i++) begin
            le_s[i] = (N_W'(i) < count_r) && (dist_r[i] <= d_r);
        end
        if (le_s[0]) begin
            ins_dist_s[0] = dist_r[0];
            ins_lab_s[0]  = lab_r[0];
        end else begin
            ins_dist_s[0] = d_r;
            ins_lab_s[0]  = lab_in_r;
        end
        for (int i = 1; i < K; i++) begin
            if (le_s[i]) begin
                ins_dist_s[i] = dist_r[i];
                ins_lab_s[i]  = lab_r[i];
            end else if (le_s[i-1]) begin
                ins_dist_s[i] = d_r;
                ins_lab_s[i]  = lab_in_r;
            end else begin
                ins_dist_s[i] = dist_r[i-1];
                ins_lab_s[i]  = lab_r[i-1];
            end
        end
    end

    // Neighbour list storage
    always_ff @(posedge clk) begin
        if (!rst || accept_s) begin
            for (int i = 0; i < K; i++) begin
                dist_r[i] <= {DIST_W{1'b1}};
                lab_r[i]  <= {LABEL_W{1'b0}};
            end
            count_r <= {N_W{1'b0}};
        end else if (insert_s) begin
            dist_r <= ins_dist_s;
            lab_r  <= ins_lab_s;
            if (count_r < N_W'(K)) begin
                count_r <= count_r + N_W'(1);
            end
        end
    end

    assign mem_rd   = mem_rd_r;
    assign mem_addr = mem_addr_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign nb_count = count_r;

    for (genvar g = 0; g < K; g++) begin : g_flat
        assign nb_dist[g*DIST_W +: DIST_W]    = dist_r[g];
        assign nb_label[g*LABEL_W +: LABEL_W] = lab_r[g];
    end

endmodule

// File: tb/tb_knn_sched.sv
// Directed self-checking bench for knn_sched with a one-cycle-latency training memory.
module tb_knn_sched;
    localparam int CW = 16;
    localparam int LW = 8;
    localparam int NW = 10;
    localparam int K  = 10;
    localparam int DW = 33;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2*CW-1:0] test_pt;
    logic [NW-1:0]   n_points;
    logic            mem_rd;
    logic [NW-1:0]   mem_addr;
    logic [2*CW-1:0] mem_pt;
    logic [LW-1:0]   mem_label;
    logic            busy;
    logic            done;
    logic [NW-1:0]   nb_count;
    logic [K*DW-1:0] nb_dist;
    logic [K*LW-1:0] nb_label;

    int total = 0;
    int bad   = 0;
    int addr_bad = 0;
    logic [NW-1:0] cur_n = '0;

    logic [CW-1:0] mx [0:15];
    logic [CW-1:0] my [0:15];
    logic [LW-1:0] ml [0:15];
    logic [DW-1:0] exp_d [K];
    logic [LW-1:0] exp_l [K];

    knn_sched dut (
        .clk(clk), .rst(rst), .start(start), .test_pt(test_pt), .n_points(n_points),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_pt(mem_pt), .mem_label(mem_label),
        .busy(busy), .done(done), .nb_count(nb_count), .nb_dist(nb_dist), .nb_label(nb_label)
    );

    always #5 clk = ~clk;

    // Training memory: data valid only in the cycle after the read strobe, garbage otherwise
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_pt    <= {mx[mem_addr[3:0]], my[mem_addr[3:0]]};
            mem_label <= ml[mem_addr[3:0]];
            if (mem_addr >= cur_n) addr_bad <= addr_bad + 1;
        end else begin
            mem_pt    <= 32'hDEAD_BEEF;
            mem_label <= 8'hEE;
        end
    end

    task automatic clear_exp();
        for (int i = 0; i < K; i++) begin
            exp_d[i] = {DW{1'b1}};
            exp_l[i] = 8'd0;
        end
    endtask

    task automatic do_run(input logic [NW-1:0] n, input logic [2*CW-1:0] tp, input int extra_at,
                          output int cyc, output int rds, output int dones, output logic busy1);
        cur_n    = n;
        test_pt  = tp;
        n_points = n;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = -1; rds = 0; dones = 0; busy1 = 1'b0;
        if (mem_rd) rds++;
        for (int c = 1; c <= 120; c++) begin
            if (c == extra_at) begin
                start    = 1'b1;
                test_pt  = ~tp;
                n_points = 10'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 1) busy1 = busy;
            if (mem_rd) rds++;
            if (done) begin
                dones++;
                if (cyc < 0) cyc = c;
            end
            if (cyc >= 0 && c >= cyc + 4) break;
        end
    endtask

    task automatic test_reset();
        int dones;
        int rds;
        rst = 1'b0; start = 1'b0; test_pt = '0; n_points = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
        total++; if (mem_addr !== 10'd0) begin bad++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
        total++; if (nb_count !== 10'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", nb_count); end
        rst = 1'b1;
        // start a run and reset it partway through
        cur_n = 10'd5; test_pt = '0; n_points = 10'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++; if (nb_count !== 10'd1) begin bad++; $display("FAIL midrun_count got=%0d exp=1", nb_count); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mreset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mreset_done got=%b exp=0", done); end
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL mreset_mem_rd got=%b exp=0", mem_rd); end
        total++; if (nb_count !== 10'd0) begin bad++; $display("FAIL mreset_count got=%0d exp=0", nb_count); end
        for (int i = 0; i < K; i++) begin
            total++;
            if (nb_dist[i*DW +: DW] !== 33'h1_FFFF_FFFF || nb_label[i*LW +: LW] !== 8'd0) begin
                bad++;
                $display("FAIL mreset_entry%0d got=%h/%h exp=1ffffffff/00", i, nb_dist[i*DW +: DW], nb_label[i*LW +: LW]);
            end
        end
        rst = 1'b1;
        dones = 0; rds = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (mem_rd) rds++;
        end
        total++; if (dones != 0 || rds != 0) begin bad++; $display("FAIL mreset_quiet got=%0d/%0d exp=0/0", dones, rds); end
    endtask

    task automatic test_basic();
        int cyc; int rds; int dones; logic b1;
        mx[0] = 16'd3; my[0] = 16'd4; ml[0] = 8'd1;
        mx[1] = 16'd0; my[1] = 16'd1; ml[1] = 8'd2;
        mx[2] = 16'd1; my[2] = 16'd1; ml[2] = 8'd3;
        do_run(10'd3, 32'h0, 0, cyc, rds, dones, b1);
        clear_exp();
        exp_d[0] = 33'd1;  exp_l[0] = 8'd2;
        exp_d[1] = 33'd2;  exp_l[1] = 8'd3;
        exp_d[2] = 33'd25; exp_l[2] = 8'd1;
        total++; if (cyc != 13) begin bad++; $display("FAIL basic_latency got=%0d exp=13", cyc); end
        total++; if (dones != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", dones); end
        total++; if (rds != 3) begin bad++; $display("FAIL basic_reads got=%0d exp=3", rds); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", b1); end
        total++; if (nb_count !== 10'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", nb_count); end
        for (int i = 0; i < K; i++) begin
            total++;
            if (nb_dist[i*DW +: DW] !== exp_d[i] || nb_label[i*LW +: LW] !== exp_l[i]) begin
                bad++;
                $display("FAIL basic_entry%0d got=%0d/%0d exp=%0d/%0d", i, nb_dist[i*DW +: DW], nb_label[i*LW +: LW], exp_d[i], exp_l[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || nb_count !== 10'd3 || nb_dist[0 +: DW] !== 33'd1) begin
            bad++; $display("FAIL basic_hold got=%b/%0d/%0d exp=0/3/1", busy, nb_count, nb_dist[0 +: DW]);
        end
    endtask

    task automatic test_overflow();
        int cyc; int rds; int dones; logic b1;
        for (int k = 0; k < 12; k++) begin
            mx[k] = 16'(11 - k); my[k] = 16'd0; ml[k] = 8'(11 - k);
        end
        do_run(10'd12, 32'h0, 0, cyc, rds, dones, b1);
        total++; if (cyc != 49) begin bad++; $display("FAIL ovf_latency got=%0d exp=49", cyc); end
        total++; if (rds != 12) begin bad++; $display("FAIL ovf_reads got=%0d exp=12", rds); end
        total++; if (nb_count !== 10'd10) begin bad++; $display("FAIL ovf_count got=%0d exp=10", nb_count); end
        for (int j = 0; j < K; j++) begin
            total++;
            if (nb_dist[j*DW +: DW] !== 33'(j*j) || nb_label[j*LW +: LW] !== 8'(j)) begin
                bad++;
                $display("FAIL ovf_entry%0d got=%0d/%0d exp=%0d/%0d", j, nb_dist[j*DW +: DW], nb_label[j*LW +: LW], j*j, j);
            end
        end
    endtask

    task automatic test_ties_busy();
        int cyc; int rds; int dones; logic b1;
        mx[0] = 16'd1;    my[0] = 16'd2; ml[0] = 8'd7;
        mx[1] = 16'd2;    my[1] = 16'd1; ml[1] = 8'd8;
        mx[2] = 16'hFFFE; my[2] = 16'd1; ml[2] = 8'd9;
        do_run(10'd3, 32'h0, 6, cyc, rds, dones, b1);
        total++; if (cyc != 13) begin bad++; $display("FAIL ties_latency got=%0d exp=13", cyc); end
        total++; if (dones != 1) begin bad++; $display("FAIL ties_done_pulses got=%0d exp=1", dones); end
        total++; if (nb_count !== 10'd3) begin bad++; $display("FAIL ties_count got=%0d exp=3", nb_count); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (nb_dist[i*DW +: DW] !== 33'd5 || nb_label[i*LW +: LW] !== 8'(7 + i)) begin
                bad++;
                $display("FAIL ties_entry%0d got=%0d/%0d exp=5/%0d", i, nb_dist[i*DW +: DW], nb_label[i*LW +: LW], 7 + i);
            end
        end
    endtask

    task automatic test_zero();
        int cyc; int rds; int dones; logic b1;
        do_run(10'd0, 32'h0, 0, cyc, rds, dones, b1);
        total++; if (cyc != 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", cyc); end
        total++; if (rds != 0) begin bad++; $display("FAIL zero_reads got=%0d exp=0", rds); end
        total++; if (dones != 1) begin bad++; $display("FAIL zero_done_pulses got=%0d exp=1", dones); end
        total++; if (nb_count !== 10'd0) begin bad++; $display("FAIL zero_count got=%0d exp=0", nb_count); end
        total++; if (nb_dist[0 +: DW] !== 33'h1_FFFF_FFFF) begin bad++; $display("FAIL zero_entry0 got=%h exp=1ffffffff", nb_dist[0 +: DW]); end
    endtask

    task automatic test_extreme();
        int cyc; int rds; int dones; logic b1;
        mx[0] = 16'h7FFF; my[0] = 16'h7FFF; ml[0] = 8'd5;
        do_run(10'd1, 32'h8000_8000, 0, cyc, rds, dones, b1);
        total++; if (cyc != 5) begin bad++; $display("FAIL ext_latency got=%0d exp=5", cyc); end
        total++; if (nb_count !== 10'd1) begin bad++; $display("FAIL ext_count got=%0d exp=1", nb_count); end
        total++; if (nb_dist[0 +: DW] !== 33'h1_FFFC_0002) begin bad++; $display("FAIL ext_dist got=%h exp=1fffc0002", nb_dist[0 +: DW]); end
        total++; if (nb_label[0 +: LW] !== 8'd5) begin bad++; $display("FAIL ext_label got=%0d exp=5", nb_label[0 +: LW]); end
        total++; if (nb_dist[DW +: DW] !== 33'h1_FFFF_FFFF) begin bad++; $display("FAIL ext_entry1 got=%h exp=1ffffffff", nb_dist[DW +: DW]); end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            mx[k] = '0; my[k] = '0; ml[k] = '0;
        end
        test_reset();
        test_basic();
        test_overflow();
        test_ties_busy();
        test_zero();
        test_extreme();
        total++; if (addr_bad != 0) begin bad++; $display("FAIL addr_range got=%0d exp=0", addr_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
